// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration arbiter, spi_master and the
// per-device configuration sequencers.
package spi_cfg_pkg;

  // Default bus widths shared with spi_master and the cfg sequencers.
  localparam int CFG_MOSI_DATA_WIDTH  = 24;  // 16-bit instruction header + 8-bit data
  localparam int CFG_MISO_DATA_WIDTH  = 8;
  localparam int CFG_INSTR_HEADER_LEN = 16;

  // Largest requester count the index helper handles.
  localparam int CFG_MAX_REQ = 8;

  // Arbiter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // One-hot to binary index. Bits are OR-ed together, so a one-hot input
  // gives its position and an all-zero input gives 0.
  function automatic logic [2:0] onehot_to_idx(input logic [CFG_MAX_REQ-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < CFG_MAX_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after the pointer, wrapping around, as both one-hot and binary index.
module spi_rr_pick
  import spi_cfg_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Scan from the pointer forward and keep only the first hit.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    pos    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      pos = IDX_W'((int'(ptr) + off) % N_REQ);
      if (!found && req[pos]) begin
        onehot[pos] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign idx = IDX_W'(onehot_to_idx(CFG_MAX_REQ'(onehot)));

endmodule

// File: rtl/spi_cfg_arbiter.sv
// Round-robin arbiter that lends the single spi_master to one configuration
// sequencer for a whole sequence, forwards its commands and steers cs_n.
// Optional idle-grant watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_cfg_arbiter
  import spi_cfg_pkg::*;
#(
  parameter int N_REQ           = 3,
  parameter int MOSI_DATA_WIDTH = CFG_MOSI_DATA_WIDTH,
  parameter int MISO_DATA_WIDTH = CFG_MISO_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES  = 1048576
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               i_req,
  output logic [N_REQ-1:0]               o_gnt,
  input  logic [N_REQ-1:0]               i_wr_cmd,
  input  logic [N_REQ-1:0]               i_rd_cmd,
  input  logic [N_REQ*MOSI_DATA_WIDTH-1:0] i_wr_data,
  output logic [N_REQ-1:0]               o_busy,
  output logic [MISO_DATA_WIDTH:0]       o_rd_data,
  output logic                           o_spi_wr_cmd,
  output logic                           o_spi_rd_cmd,
  output logic [MOSI_DATA_WIDTH-1:0]     o_spi_wr_data,
  input  logic                           i_spi_busy,
  input  logic [MISO_DATA_WIDTH:0]       i_spi_rd_data,
  input  logic                           i_spi_cs_n,
  output logic [N_REQ-1:0]               o_cs_n,
  output logic                           o_timeout
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t               state_reg, state_next;
  logic [N_REQ-1:0]         gnt_reg, gnt_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic [IDX_W-1:0]         rr_ptr_reg, rr_ptr_next;
  logic                     wr_cmd_reg, wr_cmd_next;
  logic                     rd_cmd_reg, rd_cmd_next;
  logic [MOSI_DATA_WIDTH-1:0] wr_data_reg, wr_data_next;

  logic [N_REQ-1:0]         pick_onehot;
  logic [IDX_W-1:0]         pick_idx;
  logic [MOSI_DATA_WIDTH-1:0] slot_data [N_REQ];
  logic                     slot_req, slot_wr, slot_rd;
  logic                     fwd_wr, fwd_rd, pending;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;
`endif

  spi_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (i_req),
    .ptr    (rr_ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Unpack the write words and build per-pin cs_n / busy views.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign slot_data[gi] = i_wr_data[gi*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
      assign o_cs_n[gi]    = gnt_reg[gi] ? i_spi_cs_n : 1'b1;
      // Non-granted sequencers always see busy so they never start a transfer.
      assign o_busy[gi]    = gnt_reg[gi] ? (i_spi_busy | pending) : 1'b1;
    end
  endgenerate

  assign slot_req = i_req[idx_reg];
  assign slot_wr  = i_wr_cmd[idx_reg];
  assign slot_rd  = i_rd_cmd[idx_reg];
  // A simultaneous write and read from the holder: the write wins.
  assign fwd_wr   = slot_wr & ~i_spi_busy;
  assign fwd_rd   = slot_rd & ~slot_wr & ~i_spi_busy;
  // Command registered towards spi_master but not yet reflected in its busy.
  assign pending  = wr_cmd_reg | rd_cmd_reg;

  assign o_gnt         = gnt_reg;
  assign o_spi_wr_cmd  = wr_cmd_reg;
  assign o_spi_rd_cmd  = rd_cmd_reg;
  assign o_spi_wr_data = wr_data_reg;
  assign o_rd_data     = i_spi_rd_data;

  // Next-state and registered-output logic of the grant FSM.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    idx_next     = idx_reg;
    rr_ptr_next  = rr_ptr_reg;
    wr_cmd_next  = 1'b0;
    rd_cmd_next  = 1'b0;
    wr_data_next = wr_data_reg;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (|i_req) begin
          gnt_next   = pick_onehot;
          idx_next   = pick_idx;
          state_next = GRANT;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      GRANT: begin
        wr_cmd_next = fwd_wr;
        rd_cmd_next = fwd_rd;
        if (fwd_wr | fwd_rd) begin
          wr_data_next = slot_data[idx_reg];
        end
        if (!slot_req) begin
          state_next = DRAIN;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        if (fwd_wr | fwd_rd) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next   = DRAIN;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      DRAIN: begin
        // Release only once spi_master is idle and nothing is still queued to it.
        if (!i_spi_busy && !pending) begin
          gnt_next    = '0;
          rr_ptr_next = IDX_W'((int'(idx_reg) + 1) % N_REQ);
          state_next  = IDLE;
        end
      end
      default: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns the bus to all-idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      idx_reg     <= '0;
      rr_ptr_reg  <= '0;
      wr_cmd_reg  <= 1'b0;
      rd_cmd_reg  <= 1'b0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      idx_reg     <= idx_next;
      rr_ptr_reg  <= rr_ptr_next;
      wr_cmd_reg  <= wr_cmd_next;
      rd_cmd_reg  <= rd_cmd_next;
      wr_data_reg <= wr_data_next;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign o_timeout = timeout_reg;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Directed self-checking bench for spi_cfg_arbiter (3 requesters).
// Define SPI_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_spi_cfg_arbiter;

  localparam int N  = 3;
  localparam int W  = 24;
  localparam int RW = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   i_req, o_gnt, i_wr_cmd, i_rd_cmd, o_busy, o_cs_n;
  logic [N*W-1:0] i_wr_data;
  logic [RW-1:0]  o_rd_data, i_spi_rd_data;
  logic           o_spi_wr_cmd, o_spi_rd_cmd, i_spi_busy, i_spi_cs_n, o_timeout;
  logic [W-1:0]   o_spi_wr_data;

  int checks   = 0;
  int failures = 0;

  spi_cfg_arbiter #(
    .N_REQ           (N),
    .MOSI_DATA_WIDTH (W),
    .MISO_DATA_WIDTH (RW-1),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req         (i_req),
    .o_gnt         (o_gnt),
    .i_wr_cmd      (i_wr_cmd),
    .i_rd_cmd      (i_rd_cmd),
    .i_wr_data     (i_wr_data),
    .o_busy        (o_busy),
    .o_rd_data     (o_rd_data),
    .o_spi_wr_cmd  (o_spi_wr_cmd),
    .o_spi_rd_cmd  (o_spi_rd_cmd),
    .o_spi_wr_data (o_spi_wr_data),
    .i_spi_busy    (i_spi_busy),
    .i_spi_rd_data (i_spi_rd_data),
    .i_spi_cs_n    (i_spi_cs_n),
    .o_cs_n        (o_cs_n),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("[%0t] %s observed=0x%0h expected=0x%0h", $time, tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    i_req         = '0;
    i_wr_cmd      = '0;
    i_rd_cmd      = '0;
    i_wr_data     = '0;
    i_spi_busy    = 1'b0;
    i_spi_rd_data = '0;
    i_spi_cs_n    = 1'b1;
    #3;
    chk("rst_gnt",     32'(o_gnt), 32'h0);
    chk("rst_cs_n",    32'(o_cs_n), 32'h7);
    chk("rst_wr_cmd",  32'(o_spi_wr_cmd), 32'h0);
    chk("rst_rd_cmd",  32'(o_spi_rd_cmd), 32'h0);
    chk("rst_wr_data", 32'(o_spi_wr_data), 32'h0);
    chk("rst_timeout", 32'(o_timeout), 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Single requester, one write.
    i_req = 3'b001;
    tick();
    chk("t1_gnt", 32'(o_gnt), 32'h1);
    chk("t1_busy_idle", 32'(o_busy), 32'h6);
    i_wr_data = {24'h0, 24'h0, 24'h000190};
    i_wr_cmd  = 3'b001;
    tick();
    chk("t1_wr_cmd", 32'(o_spi_wr_cmd), 32'h1);
    chk("t1_wr_data", 32'(o_spi_wr_data), 32'h000190);
    chk("t1_rd_cmd", 32'(o_spi_rd_cmd), 32'h0);
    chk("t1_busy_pending", 32'(o_busy), 32'h7);
    i_wr_cmd   = '0;
    i_spi_busy = 1'b1;
    i_spi_cs_n = 1'b0;
    #1;
    chk("t1_cs_n_low", 32'(o_cs_n), 32'h6);
    tick();
    chk("t1_wr_cmd_single", 32'(o_spi_wr_cmd), 32'h0);
    i_spi_busy = 1'b0;
    i_spi_cs_n = 1'b1;
    i_req      = '0;
    tick();
    chk("t1_drain_gnt", 32'(o_gnt), 32'h1);
    tick();
    chk("t1_release_gnt", 32'(o_gnt), 32'h0);
    chk("t1_release_cs_n", 32'(o_cs_n), 32'h7);

    i_spi_rd_data = 9'h1A5;
    #1;
    chk("rd_passthrough", 32'(o_rd_data), 32'h1A5);

    // Restart from reset so the pointer is back at 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req = 3'b111;
    tick();
    chk("t2_first_gnt", 32'(o_gnt), 32'h1);

    // Non-granted requester 2 issues a write: must be dropped.
    i_wr_data = {24'h123456, 24'h0, 24'h0};
    i_wr_cmd  = 3'b100;
    tick();
    chk("t2_ng_wr_cmd", 32'(o_spi_wr_cmd), 32'h0);
    chk("t2_ng_busy2", 32'(o_busy[2]), 32'h1);

    // Write and read together on the granted slot: write wins.
    i_wr_data = {24'h0, 24'h0, 24'hABCDEF};
    i_wr_cmd  = 3'b001;
    i_rd_cmd  = 3'b001;
    tick();
    chk("t2_both_wr", 32'(o_spi_wr_cmd), 32'h1);
    chk("t2_both_rd", 32'(o_spi_rd_cmd), 32'h0);
    chk("t2_both_data", 32'(o_spi_wr_data), 32'hABCDEF);
    chk("t2_ng_busy2_b", 32'(o_busy[2]), 32'h1);
    i_wr_cmd = '0;
    i_rd_cmd = '0;

    // Requester 0 releases while spi_master is still busy.
    i_spi_busy = 1'b1;
    i_req      = 3'b110;
    tick();
    chk("t3_drain_gnt_a", 32'(o_gnt), 32'h1);
    tick();
    chk("t3_drain_gnt_b", 32'(o_gnt), 32'h1);
    tick();
    chk("t3_drain_gnt_c", 32'(o_gnt), 32'h1);
    i_spi_busy = 1'b0;
    tick();
    chk("t3_idle_gnt", 32'(o_gnt), 32'h0);
    chk("t3_idle_cs_n", 32'(o_cs_n), 32'h7);
    tick();
    chk("t3_second_gnt", 32'(o_gnt), 32'h2);

    // Read forwarding from requester 1.
    i_rd_cmd = 3'b010;
    tick();
    chk("t3_rd_cmd", 32'(o_spi_rd_cmd), 32'h1);
    chk("t3_rd_no_wr", 32'(o_spi_wr_cmd), 32'h0);
    i_rd_cmd = '0;

    i_req = 3'b100;
    tick();
    chk("t3_drain1_gnt", 32'(o_gnt), 32'h2);
    tick();
    chk("t3_idle1_gnt", 32'(o_gnt), 32'h0);
    tick();
    chk("t3_third_gnt", 32'(o_gnt), 32'h4);
    i_spi_cs_n = 1'b0;
    #1;
    chk("t3_cs_n_dev2", 32'(o_cs_n), 32'h3);

    // Asynchronous reset between clock edges.
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(o_gnt), 32'h0);
    chk("async_rst_cs_n", 32'(o_cs_n), 32'h7);
    i_spi_cs_n = 1'b1;
    i_req      = '0;
    tick();
    rst = 1'b0;

`ifdef SPI_ARB_TIMEOUT_EN
    // Idle holder is forced off after 16 grant cycles without commands.
    i_req = 3'b001;
    tick();
    chk("to_gnt", 32'(o_gnt), 32'h1);
    repeat (15) tick();
    chk("to_hold_gnt", 32'(o_gnt), 32'h1);
    chk("to_hold_flag", 32'(o_timeout), 32'h0);
    tick();
    chk("to_flag", 32'(o_timeout), 32'h1);
    tick();
    chk("to_release_gnt", 32'(o_gnt), 32'h0);
    i_req = '0;
    tick();
    chk("to_sticky", 32'(o_timeout), 32'h1);
`else
    // Without the watchdog a silent holder keeps the bus.
    i_req = 3'b001;
    tick();
    chk("hold_gnt", 32'(o_gnt), 32'h1);
    repeat (40) tick();
    chk("hold_gnt_long", 32'(o_gnt), 32'h1);
    chk("hold_no_timeout", 32'(o_timeout), 32'h0);
    i_req = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cfg_arbiter.md
Name: spi_cfg_arbiter

Overview:
- Sits between the per-device configuration sequencers (AD9517 clock chip, ADC0, ADC1) and the single shared spi_master on the 3-wire SPI bus.
- Grants the bus to one sequencer for its whole configuration sequence using round-robin among pending requests.
- Forwards the granted sequencer's write/read commands and data to spi_master.
- Steers spi_master's chip select to that device's cs_n pin only; all other cs_n pins stay high.

Parameters:
- N_REQ, 3, number of requesting sequencers / chip selects (2..8).
- MOSI_DATA_WIDTH, 24, write word width (16-bit instruction header + 8-bit data).
- MISO_DATA_WIDTH, 8, read data width; the read bus is MISO_DATA_WIDTH+1 bits, matching spi_master.
- TIMEOUT_CYCLES, 1048576, idle-grant watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system config clock (clk_20m domain).
- rst  in  1  asynchronous, active-high reset.
- i_req  in  N_REQ  per-sequencer bus request; level, held for the whole sequence.
- o_gnt  out  N_REQ  one-hot grant; acts as that sequencer's cfg_go.
- i_wr_cmd  in  N_REQ  per-sequencer write pulse.
- i_rd_cmd  in  N_REQ  per-sequencer read pulse.
- i_wr_data  in  N_REQ*MOSI_DATA_WIDTH  packed write words; slot k = bits [k*W +: W].
- o_busy  out  N_REQ  per-sequencer busy.
- o_rd_data  out  MISO_DATA_WIDTH+1  read data broadcast to all sequencers.
- o_spi_wr_cmd  out  1  to spi_master.
- o_spi_rd_cmd  out  1  to spi_master.
- o_spi_wr_data  out  MOSI_DATA_WIDTH  to spi_master.
- i_spi_busy  in  1  from spi_master.
- i_spi_rd_data  in  MISO_DATA_WIDTH+1  from spi_master.
- i_spi_cs_n  in  1  from spi_master ncs_pin.
- o_cs_n  out  N_REQ  per-device chip selects to pins.
- o_timeout  out  1  sticky watchdog flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset values: state=IDLE; o_gnt=0; o_spi_wr_cmd=0; o_spi_rd_cmd=0; o_spi_wr_data=0; rr pointer=0; o_timeout=0. o_cs_n is all 1s (combinational while IDLE).
- States:
  - IDLE: if any i_req is set, pick the first set bit at or after the rr pointer (wrapping). Next cycle: o_gnt=onehot(k), go to GRANT. No request: stay in IDLE.
  - GRANT: forward commands from slot k only, registered, one cycle of latency: o_spi_wr_cmd <= i_wr_cmd[k] & ~i_spi_busy, and the same for rd. o_spi_wr_data <= slot k when either command is accepted. If i_wr_cmd[k] and i_rd_cmd[k] arrive together, the write wins and the read is dropped. When i_req[k] falls, go to DRAIN.
  - DRAIN: o_gnt stays asserted. New commands are ignored. When i_spi_busy=0 and no command is in flight (o_spi_*_cmd=0), clear o_gnt, set rr pointer=(k+1) mod N_REQ, go to IDLE. There is at least one IDLE cycle between grants.
- o_busy[j] = i_spi_busy | pending-forward flag for j==k; o_busy[j] = 1 for every j≠k. A non-granted sequencer therefore never sees idle.
- o_cs_n[k] = i_spi_cs_n while granted; all other bits are 1. In IDLE all bits are 1.
- o_rd_data = i_spi_rd_data, combinational passthrough.
- Commands from non-granted slots are discarded silently, never queued.
- A request arriving during GRANT or DRAIN waits. The newly released slot gets lowest priority in the next arbitration.
- Async rst mid-transaction:
  - Everything returns to reset values immediately.
  - spi_master shares this reset domain and aborts with it.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- With it: a counter clears on each forwarded command and on each grant, and increments in GRANT while no command is forwarded. When it reaches TIMEOUT_CYCLES-1, the arbiter forces DRAIN, sets sticky o_timeout=1 (cleared only by rst), and advances the rr pointer past the offender.
- Without it: no counter, o_timeout tied 0, and a hung requester holds the bus indefinitely.

Decomposition:
- Package spi_cfg_pkg holds:
  - state encoding (IDLE, GRANT, DRAIN);
  - default MOSI_DATA_WIDTH / MISO_DATA_WIDTH / INSTR_HEADER_LEN constants shared with spi_master and the cfg sequencers;
  - a function for the one-hot-to-index conversion.
- One sub-module, spi_rr_pick: combinational round-robin picker. Inputs: req vector and pointer. Outputs: one-hot and index.

Test Plan:
- Single requester: i_req=3'b001, one wr_cmd with data 24'h000190 → o_gnt=001 one cycle later; o_spi_wr_cmd pulses once with data 0x000190; o_cs_n=110 while i_spi_cs_n is low.
- Simultaneous requests 3'b111 from reset → grants in order 001, 010, 100, each separated by at least one IDLE cycle; all o_cs_n bits=1 in between.
- Release with busy: requester 0 drops i_req while i_spi_busy=1 → o_gnt stays 001 until busy falls, then releases; requester 1 is granted next.
- Non-granted command: requester 2 pulses wr_cmd while requester 0 is granted → no o_spi_wr_cmd pulse; o_busy[2]=1 throughout.
- Simultaneous wr and rd on the granted slot with busy=0 → only o_spi_wr_cmd pulses; o_spi_rd_cmd stays 0.
- Async rst asserted mid-GRANT → o_gnt=0 and o_cs_n=111 with no clock edge. With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, an idle holder is released after 16 cycles and o_timeout=1.
